// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store front-end: access sizes, error codes, FSM states.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_SIZE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_extract.sv
// Picks the byte/half/word lane out of a memory word and sign- or zero-extends it.
// Purely combinational so it can be shared with a bypass path.
module mau_lane_extract
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign shifted = word >> {off, 3'b000};
  assign lane_b  = shifted[7:0];
  assign lane_h  = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (size)
      SZ_BYTE: data = sgn ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
      SZ_HALF: data = sgn ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end: one request -> fault check -> one memory cycle -> one response.
// Fixed 3-cycle turnaround; faults still take the ACCESS slot but never touch memory.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          DM_AW     = 11,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic [DM_AW-1:0] dm_a,
  output logic [3:0]       dm_be,
  output logic [31:0]      dm_wd,
  output logic             dm_we,
  input  logic [31:0]      dm_rd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic [1:0]       rsp_err,
  output logic [CNT_W-1:0] err_count
);

  state_t           state_q, state_d;
  logic             we_q, sgn_q;
  logic [1:0]       size_q, off_q, err_q;
  logic [3:0]       be_q;
  logic [DM_AW-1:0] a_q;
  logic [31:0]      wd_q;
  logic [1:0]       err_in;
  logic [31:0]      ld_data;
  logic             accept;

  always_comb begin
    err_in = ERR_OK;
    if (req_size == SZ_ILL)
      err_in = ERR_SIZE;
    else if (req_addr[31:DM_AW+2] != ADDR_BASE[31:DM_AW+2])
      err_in = ERR_RANGE;
    else if ((req_size == SZ_HALF && req_addr[0]) ||
             (req_size == SZ_WORD && req_addr[1:0] != 2'b00))
      err_in = ERR_ALIGN;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ACCESS;
      end
      ACCESS: state_d = RESP;
      RESP:   if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = (state_q == IDLE) && req_valid;

  // Memory strobes are decoded from state so an async reset kills them immediately.
  assign dm_a      = a_q;
  assign dm_be     = (state_q == ACCESS && err_q == ERR_OK) ? be_q : 4'b0000;
  assign dm_we     = (state_q == ACCESS) && (err_q == ERR_OK) && we_q;
  assign dm_wd     = (state_q == ACCESS) ? wd_q : 32'h0;
  assign rsp_valid = (state_q == RESP);

  mau_lane_extract u_lane (
    .word (dm_rd),
    .off  (off_q),
    .size (size_q),
    .sgn  (sgn_q),
    .data (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      sgn_q     <= 1'b0;
      size_q    <= SZ_BYTE;
      off_q     <= 2'b00;
      err_q     <= ERR_OK;
      be_q      <= 4'b0000;
      a_q       <= '0;
      wd_q      <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= ERR_OK;
      err_count <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q   <= req_we;
        sgn_q  <= req_signed;
        size_q <= req_size;
        off_q  <= req_addr[1:0];
        err_q  <= err_in;
        be_q   <= byte_en(req_size, req_addr[1:0]);
        a_q    <= req_addr[DM_AW+1:2];
        wd_q   <= req_wdata;
      end
      if (state_q == ACCESS) begin
        rsp_err   <= err_q;
        rsp_rdata <= (err_q == ERR_OK && !we_q) ? ld_data : 32'h0;
        if (err_q != ERR_OK && err_count != {CNT_W{1'b1}})
          err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule
